// File: rtl/pwm_multichannel_ctrl.sv
// Register-programmed multichannel PWM with prescaler and duty updates aligned to period wraps.
// Define PWM_PHASE_OFFSET_EN to add per-channel shadowed phase registers at 0x40+c.
module pwm_multichannel_ctrl #(
    parameter int CHANNELS   = 16,
    parameter int CNT_W      = 8,
    parameter int ADDR_W     = 7,
    parameter int PRESCALE_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_valid,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [7:0]          wr_data,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_stb
);
    localparam int BANKS = CHANNELS / 8;
    localparam logic [CNT_W-1:0] DUTY_FULL = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LAST  = {{(CNT_W-1){1'b1}}, 1'b0};

    logic [CHANNELS-1:0]   out_en_q, out_en_d;
    logic [CHANNELS-1:0]   pwm_en_q, pwm_en_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]      duty_shadow_q [CHANNELS];
    logic [CNT_W-1:0]      duty_shadow_d [CHANNELS];
    logic [CNT_W-1:0]      duty_active_q [CHANNELS];
    logic [CNT_W-1:0]      duty_active_d [CHANNELS];
`ifdef PWM_PHASE_OFFSET_EN
    logic [CNT_W-1:0]      phase_shadow_q [CHANNELS];
    logic [CNT_W-1:0]      phase_shadow_d [CHANNELS];
    logic [CNT_W-1:0]      phase_active_q [CHANNELS];
    logic [CNT_W-1:0]      phase_active_d [CHANNELS];
    logic [CNT_W:0]        phase_sum;
`endif
    logic [CHANNELS-1:0]   pwm_out_q, pwm_out_d;
    logic                  period_stb_q;
    logic                  tick;
    logic                  wrap;
    logic [31:0]           addr_ext;
    logic [15:0]           prescale_wide;
    logic [CNT_W-1:0]      pos;

    always_comb begin
        tick          = (pre_cnt_q == prescale_q);
        wrap          = tick && (cnt_q == CNT_LAST);
        addr_ext      = 32'(wr_addr);
        prescale_wide = 16'(prescale_q);
        out_en_d      = out_en_q;
        pwm_en_d      = pwm_en_q;
        prescale_d    = prescale_q;
        pre_cnt_d     = tick ? '0 : pre_cnt_q + 1'b1;
        cnt_d         = cnt_q;
        if (tick) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
        end
        duty_shadow_d = duty_shadow_q;
        duty_active_d = duty_active_q;
`ifdef PWM_PHASE_OFFSET_EN
        phase_shadow_d = phase_shadow_q;
        phase_active_d = phase_active_q;
`endif
        // The wrap copies the shadow as it stood before any write landing on this same edge.
        if (wrap) begin
            duty_active_d = duty_shadow_q;
`ifdef PWM_PHASE_OFFSET_EN
            phase_active_d = phase_shadow_q;
`endif
        end
        if (wr_valid) begin
            for (int k = 0; k < BANKS; k++) begin
                if (addr_ext == 32'(k)) begin
                    out_en_d[8*k +: 8] = wr_data;
                end
                if (addr_ext == 32'(4 + k)) begin
                    pwm_en_d[8*k +: 8] = wr_data;
                end
            end
            if (addr_ext == 32'h8) begin
                prescale_wide[7:0] = wr_data;
                prescale_d         = prescale_wide[PRESCALE_W-1:0];
                pre_cnt_d          = '0;
            end
            if (addr_ext == 32'h9) begin
                prescale_wide[15:8] = wr_data;
                prescale_d          = prescale_wide[PRESCALE_W-1:0];
                pre_cnt_d           = '0;
            end
            for (int c = 0; c < CHANNELS; c++) begin
                if (addr_ext == 32'(32 + c)) begin
                    duty_shadow_d[c] = CNT_W'(wr_data);
                end
`ifdef PWM_PHASE_OFFSET_EN
                if (addr_ext == 32'(64 + c)) begin
                    phase_shadow_d[c] = CNT_W'(wr_data);
                end
`endif
            end
        end
    end

    always_comb begin
        pwm_out_d = '0;
        pos       = '0;
`ifdef PWM_PHASE_OFFSET_EN
        phase_sum = '0;
`endif
        for (int c = 0; c < CHANNELS; c++) begin
            pos = cnt_q;
`ifdef PWM_PHASE_OFFSET_EN
            // Counter plus phase folded back into the 0..2^CNT_W-2 period range.
            phase_sum = {1'b0, cnt_q} + {1'b0, phase_active_q[c]};
            if (phase_sum >= {1'b0, DUTY_FULL}) begin
                phase_sum = phase_sum - {1'b0, DUTY_FULL};
            end
            pos = phase_sum[CNT_W-1:0];
`endif
            if (!out_en_q[c]) begin
                pwm_out_d[c] = 1'b0;
            end else if (!pwm_en_q[c]) begin
                pwm_out_d[c] = 1'b1;
            end else if (duty_active_q[c] == DUTY_FULL) begin
                pwm_out_d[c] = 1'b1;
            end else begin
                pwm_out_d[c] = (pos < duty_active_q[c]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_en_q     <= '0;
            pwm_en_q     <= '0;
            prescale_q   <= '0;
            pre_cnt_q    <= '0;
            cnt_q        <= '0;
            pwm_out_q    <= '0;
            period_stb_q <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                duty_shadow_q[c] <= '0;
                duty_active_q[c] <= '0;
`ifdef PWM_PHASE_OFFSET_EN
                phase_shadow_q[c] <= '0;
                phase_active_q[c] <= '0;
`endif
            end
        end else begin
            out_en_q     <= out_en_d;
            pwm_en_q     <= pwm_en_d;
            prescale_q   <= prescale_d;
            pre_cnt_q    <= pre_cnt_d;
            cnt_q        <= cnt_d;
            pwm_out_q    <= pwm_out_d;
            period_stb_q <= wrap;
            for (int c = 0; c < CHANNELS; c++) begin
                duty_shadow_q[c] <= duty_shadow_d[c];
                duty_active_q[c] <= duty_active_d[c];
`ifdef PWM_PHASE_OFFSET_EN
                phase_shadow_q[c] <= phase_shadow_d[c];
                phase_active_q[c] <= phase_active_d[c];
`endif
            end
        end
    end

    assign pwm_out    = pwm_out_q;
    assign period_stb = period_stb_q;

endmodule
